// File: rtl/deser_pkg.sv
// Shared types and geometry helpers for the SPI command deserializer.
// Parity framing is selected by the DESER_PARITY_EN macro.
package deser_pkg;

`ifdef DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int unsigned DEF_ADDRW   = 8;
  localparam int unsigned DEF_OPCODEW = 2;

  function automatic int unsigned payload_w(input int unsigned opw, input int unsigned aw);
    return opw + 2 * aw;
  endfunction

  function automatic int unsigned frame_w(input int unsigned opw, input int unsigned aw,
                                          input bit par);
    return payload_w(opw, aw) + (par ? 1 : 0);
  endfunction

  // Command record at the default geometry.
  typedef struct packed {
    logic [DEF_OPCODEW-1:0] opcode;
    logic [DEF_ADDRW-1:0]   key_addr;
    logic [DEF_ADDRW-1:0]   text_addr;
  } cmd_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_SHIFT    = 2'd1,
    RX_DISARMED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cmd_deserializer_if.sv
// Command output bus: FIFO head, valid/ready handshake and occupancy.
interface cmd_deserializer_if #(
  parameter int unsigned ADDRW   = 8,
  parameter int unsigned OPCODEW = 2,
  parameter int unsigned DEPTH   = 4
) ();
  localparam int unsigned LVLW = $clog2(DEPTH + 1);

  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_addr;
  logic [ADDRW-1:0]   text_addr;
  logic               valid_out;
  logic               ready_in;
  logic [LVLW-1:0]    level;

  modport master (
    output opcode, key_addr, text_addr, valid_out, level,
    input  ready_in
  );

  modport slave (
    input  opcode, key_addr, text_addr, valid_out, level,
    output ready_in
  );
endinterface

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO with occupancy and simultaneous push/pop.
module cmd_fifo #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full
);
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LVLW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [LVLW-1:0] level_q, level_n;
  logic            valid_q;
  logic            pop_ok;

  assign pop_ok = pop & valid_q;

  always_comb begin
    level_n = level_q;
    case ({push, pop_ok})
      2'b10:   level_n = level_q + LVLW'(1);
      2'b01:   level_n = level_q - LVLW'(1);
      default: level_n = level_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTRW'(1);
      level_q <= level_n;
      valid_q <= (level_n != '0);
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = valid_q;
  assign level = level_q;
  assign full  = (level_q == LVLW'(DEPTH));
endmodule

// File: rtl/cmd_deserializer.sv
// SPI command receiver: synchronises SPI pins, deserialises MSB-first frames
// and queues good commands. DESER_PARITY_EN adds a trailing odd-parity bit.
module cmd_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned ADDRW       = 8,
  parameter int unsigned OPCODEW     = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               mosi,
  input  logic               cs_n,
  cmd_deserializer_if.master cmd,
  output logic               frame_err,
  output logic               overflow,
  output logic               parity_err
);
  localparam int unsigned PAYW    = payload_w(OPCODEW, ADDRW);
  localparam int unsigned FRAME_W = frame_w(OPCODEW, ADDRW, PARITY_EN);
  localparam int unsigned CNTW    = $clog2(FRAME_W + 2);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;

  // Select flops reset to "asserted" so a frame already running at release is not taken as idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  rx_state_e          state, state_n;
  logic [FRAME_W-1:0] sreg, sreg_n;
  logic [CNTW-1:0]    cnt, cnt_n;
  logic               ferr_n, perr_n, ovf_n;
  logic               push_c, pop_c, full_c, par_ok_c;
  logic [PAYW-1:0]    head_c;

  assign pop_c = cmd.valid_out & cmd.ready_in;

`ifdef DESER_PARITY_EN
  assign par_ok_c = ^sreg;
`else
  assign par_ok_c = 1'b1;
`endif

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    push_c  = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    ovf_n   = 1'b0;
    case (state)
      RX_DISARMED: if (cs_s) state_n = RX_IDLE;
      RX_IDLE: begin
        if (!cs_s) begin
          sreg_n  = '0;
          cnt_n   = '0;
          state_n = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (cs_s) begin
          state_n = RX_IDLE;
          if (cnt != CNTW'(FRAME_W))  ferr_n = 1'b1;
          else if (!par_ok_c)         perr_n = 1'b1;
          else if (full_c && !pop_c)  ovf_n  = 1'b1;
          else                        push_c = 1'b1;
        end else if (sclk_rise) begin
          sreg_n = {sreg[FRAME_W-2:0], mosi_s};
          if (cnt != CNTW'(FRAME_W + 1)) cnt_n = cnt + CNTW'(1);
        end
      end
      default: state_n = RX_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_DISARMED;
      sreg       <= '0;
      cnt        <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
      overflow   <= ovf_n;
    end
  end

  cmd_fifo #(
    .W     (PAYW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (sreg[FRAME_W-1 -: PAYW]),
    .pop   (pop_c),
    .dout  (head_c),
    .valid (cmd.valid_out),
    .level (cmd.level),
    .full  (full_c)
  );

  assign cmd.opcode    = head_c[PAYW-1 -: OPCODEW];
  assign cmd.key_addr  = head_c[2*ADDRW-1 -: ADDRW];
  assign cmd.text_addr = head_c[ADDRW-1:0];
endmodule

// File: tb/tb_cmd_deserializer.sv
// Scoreboard bench for cmd_deserializer: directed SPI frames, queued expectations.
module tb_cmd_deserializer;
  import deser_pkg::*;

  localparam int unsigned ADDRW   = 8;
  localparam int unsigned OPCODEW = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned HALF    = SYNC + 2;
  localparam int unsigned PAYW    = payload_w(OPCODEW, ADDRW);
  localparam int unsigned FW      = frame_w(OPCODEW, ADDRW, PARITY_EN);

  logic clk = 1'b0;
  logic rst_n, spi_clk, mosi, cs_n;
  logic frame_err, overflow, parity_err;

  cmd_deserializer_if #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .DEPTH(DEPTH)) cmd ();

  cmd_deserializer #(
    .ADDRW(ADDRW), .OPCODEW(OPCODEW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .cmd        (cmd),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int ferr_cnt = 0, ovf_cnt = 0, perr_cnt = 0;
  logic [PAYW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted beat must match the oldest expected command.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd.valid_out && cmd.ready_in) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   {cmd.opcode, cmd.key_addr, cmd.text_addr});
        end else begin
          check("beat", 32'({cmd.opcode, cmd.key_addr, cmd.text_addr}), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err)  ferr_cnt++;
      if (overflow)   ovf_cnt++;
      if (parity_err) perr_cnt++;
    end
  end

  function automatic logic [31:0] frame_word(input logic [OPCODEW-1:0] op,
                                             input logic [ADDRW-1:0] key,
                                             input logic [ADDRW-1:0] text,
                                             input bit flip);
    logic [PAYW-1:0] p;
    p = {op, key, text};
`ifdef DESER_PARITY_EN
    return 32'({p, (~^p) ^ flip});
`else
    return 32'(p) ^ 32'(flip & 1'b0);
`endif
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic cs_high();
    clk_wait(HALF);
    cs_n = 1'b1;
    clk_wait(HALF + 6);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      clk_wait(HALF);
      spi_clk = 1'b1;
      clk_wait(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    cs_low();
    send_bits(w, FW);
    cs_high();
  endtask

  task automatic send_good(input logic [OPCODEW-1:0] op, input logic [ADDRW-1:0] key,
                           input logic [ADDRW-1:0] text);
    exp_q.push_back({op, key, text});
    send_frame(frame_word(op, key, text, 1'b0));
  endtask

  task automatic expect_errs(input string name, input int f, input int o, input int p);
    check({name, "_frame_err"}, 32'(ferr_cnt), 32'(f));
    check({name, "_overflow"}, 32'(ovf_cnt), 32'(o));
    check({name, "_parity_err"}, 32'(perr_cnt), 32'(p));
    ferr_cnt = 0;
    ovf_cnt  = 0;
    perr_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 32'(cmd.valid_out), 32'd0);
    check({name, "_level"}, 32'(cmd.level), 32'd0);
    check({name, "_head"}, 32'({cmd.opcode, cmd.key_addr, cmd.text_addr}), 32'd0);
    check({name, "_pulses"}, 32'({frame_err, overflow, parity_err}), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; cs_n = 1'b1; spi_clk = 1'b0; mosi = 1'b0; cmd.ready_in = 1'b0;
    clk_wait(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    clk_wait(8);

    // Normal frame with consumer ready
    cmd.ready_in = 1'b1;
    send_good(2'b01, 8'hAA, 8'h55);
    check("normal_level", 32'(cmd.level), 32'd0);
    check("normal_drained", 32'(exp_q.size()), 32'd0);
    expect_errs("normal", 0, 0, 0);

    // Short (aborted) frame and long frame
    w = frame_word(2'b10, 8'h0F, 8'hF0, 1'b0);
    cs_low();
    send_bits(w >> (FW - 9), 9);
    cs_high();
    check("abort_level", 32'(cmd.level), 32'd0);
    expect_errs("abort", 1, 0, 0);
    cs_low();
    send_bits((w << 1) | 32'd1, FW + 1);
    cs_high();
    check("long_level", 32'(cmd.level), 32'd0);
    expect_errs("long", 1, 0, 0);

    // Backpressure: three queued, head held, then drain on consecutive clocks
    cmd.ready_in = 1'b0;
    send_good(2'b10, 8'h0F, 8'hF0);
    send_good(2'b11, 8'h5A, 8'hC3);
    send_good(2'b01, 8'hAA, 8'h55);
    check("bp_level", 32'(cmd.level), 32'd3);
    check("bp_valid", 32'(cmd.valid_out), 32'd1);
    check("bp_head", 32'({cmd.opcode, cmd.key_addr, cmd.text_addr}), 32'h20FF0);
    clk_wait(5);
    check("bp_head_held", 32'({cmd.opcode, cmd.key_addr, cmd.text_addr}), 32'h20FF0);
    cmd.ready_in = 1'b1;
    clk_wait(3);
    check("bp_drain_3clk", 32'(cmd.level), 32'd0);
    clk_wait(2);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    expect_errs("bp", 0, 0, 0);

    // Overflow: DEPTH+1 frames with consumer stalled
    cmd.ready_in = 1'b0;
    send_good(2'b00, 8'h11, 8'h22);
    send_good(2'b01, 8'h33, 8'h44);
    send_good(2'b10, 8'h55, 8'h66);
    send_good(2'b11, 8'h77, 8'h88);
    send_frame(frame_word(2'b01, 8'h99, 8'hEE, 1'b0));
    check("ovf_level", 32'(cmd.level), 32'(DEPTH));
    expect_errs("ovf", 0, 1, 0);
    cmd.ready_in = 1'b1;
    clk_wait(8);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_level_after", 32'(cmd.level), 32'd0);

    // Reset mid-frame with two queued; frame in flight at release is ignored
    cmd.ready_in = 1'b0;
    send_good(2'b11, 8'h01, 8'h02);
    send_good(2'b10, 8'h03, 8'h04);
    w = frame_word(2'b01, 8'hC0, 8'hDE, 1'b0);
    cs_low();
    send_bits(w >> (FW - 7), 7);
    rst_n = 1'b0;
    exp_q.delete();
    clk_wait(2);
    check_zero_outputs("midreset");
    rst_n = 1'b1;
    clk_wait(2);
    send_bits(w, FW - 7);
    cs_high();
    check("postreset_level", 32'(cmd.level), 32'd0);
    expect_errs("postreset", 0, 0, 0);
    cmd.ready_in = 1'b1;
    send_good(2'b10, 8'hBE, 8'hEF);
    check("postreset_drained", 32'(exp_q.size()), 32'd0);

`ifdef DESER_PARITY_EN
    // Parity: good frame accepted, flipped parity dropped
    send_good(2'b11, 8'h5A, 8'hC3);
    check("par_good_drained", 32'(exp_q.size()), 32'd0);
    send_frame(frame_word(2'b11, 8'h5A, 8'hC3, 1'b1));
    check("par_bad_level", 32'(cmd.level), 32'd0);
    expect_errs("par", 0, 0, 1);
`endif

    clk_wait(4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    expect_errs("final", 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cmd_deserializer.md
# cmd_deserializer

Parametrised SPI command receiver sitting between the external SPI host and the control FSM. Deserialises MSB-first frames of {opcode, key_addr, text_addr} in the system clock domain, checks frame length, and queues completed commands in a DEPTH-entry FIFO presented on a valid/ready interface. This replaces the single-pending-command deserializer, so back-to-back frames are no longer dropped while the consumer stalls.

## Interface
Parameters:
- ADDRW, 8, width of key_addr and text_addr
- OPCODEW, 2, width of opcode
- DEPTH, 4, command FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops on spi_clk/cs_n/mosi; ≥2

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- spi_clk  in  1  SPI clock, async to clk, idle low, sample on rising edge
- mosi  in  1  SPI data, async
- cs_n  in  1  SPI select, active low, async
- ready_in  in  1  consumer accepts head command
- opcode  out  OPCODEW  head command opcode
- key_addr  out  ADDRW  head command key address
- text_addr  out  ADDRW  head command text address
- valid_out  out  1  head command valid
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- frame_err  out  1  one-cycle pulse: frame dropped (wrong bit count)
- overflow  out  1  one-cycle pulse: good frame dropped, FIFO full
- parity_err  out  1  one-cycle pulse: frame dropped on parity (0 without DESER_PARITY_EN)

## Operation
- FRAME_W = OPCODEW + 2*ADDRW (+1 with parity); frame = {opcode, key, text[, parity]} MSB-first.
- spi_clk, cs_n, mosi each pass SYNC_STAGES flops; rising spi_clk detected by comparing last two synced samples.
- Receiver states: IDLE, SHIFT, DISARMED.
  - IDLE: synced cs_n falls → clear shift reg and bit counter → SHIFT.
  - SHIFT: each detected spi_clk rise shifts synced mosi into LSB; counter saturates at FRAME_W+1. Synced cs_n rise = commit cycle → IDLE.
  - DISARMED: entered out of reset; leaves to IDLE only once synced cs_n is seen high (a frame already in progress at reset release is ignored).
- Commit cycle: count == FRAME_W and parity ok → push; count ≠ FRAME_W (short/abort or long) → frame_err, no push; parity bad → parity_err, no push; FIFO full with no pop that cycle → overflow, no push.
- Full FIFO with pop in the same commit cycle: push accepted, level unchanged.
- Outputs are the FIFO head (show-ahead); stable while valid_out && !ready_in. Pop on valid_out && ready_in.
- Error pulses are mutually exclusive; priority frame_err > parity_err > overflow.

## Timing
- Reset: valid_out, level, frame_err, overflow, parity_err = 0; opcode/key_addr/text_addr = 0; state DISARMED; FIFO pointers 0.
- spi_clk high and low phases each ≥ SYNC_STAGES+1 clk periods; mosi stable over that window around rising edge; cs_n high ≥ SYNC_STAGES+1 clk between frames.
- Bit capture latency: SYNC_STAGES+1 clk after the spi_clk rise.
- Push at end of commit cycle C; valid_out high from C+1 when FIFO was empty; level updates at C+1.
- Pop at cycle P → next entry shown (or valid_out low) at P+1; sustained throughput one command per clk.
- Error pulses high exactly for cycle C+1.
- Reset mid-frame or with FIFO non-empty: all contents discarded.

## Configuration
- DESER_PARITY_EN defined: frame carries one trailing odd-parity bit over {opcode,key,text}; FRAME_W includes it; mismatch → parity_err pulse, frame dropped.
- Undefined: no parity bit, FRAME_W = OPCODEW+2*ADDRW, parity_err tied 0.

## Structure
- deser_pkg: FRAME_W / payload-width functions, packed cmd_t {opcode, key_addr, text_addr}, receiver state enum.
- Sub-module cmd_fifo (DEPTH × cmd_t, show-ahead, level output, simultaneous push/pop); synchronisers, shifter and FSM live in cmd_deserializer.

## Test plan
- Normal: ready_in=1, send {01,AA,55} → one valid_out beat with opcode=01 key=AA text=55, level returns 0.
- Abort: send top 9 bits of {10,0F,F0} then raise cs_n → frame_err pulse, no valid_out, level 0; long frame (19 bits, no parity) → frame_err.
- Backpressure: ready_in=0, send {10,0F,F0},{11,5A,C3},{01,AA,55} → level=3, head held at 10/0F/F0; release ready → three beats in order, consecutive clocks.
- Overflow: ready_in=0, send DEPTH+1 frames → level=DEPTH, one overflow pulse, last frame absent from drain.
- Reset: assert rst_n low mid-frame with 2 queued → all outputs 0; cs_n held low through reset release → remaining bits ignored, next full frame accepted.
- DESER_PARITY_EN: {11,5A,C3} with correct odd parity → accepted; flipped parity → parity_err pulse, no push.
